// File: rtl/fwd_hazard_ctrl_if.sv
// fwd_hazard_ctrl_if: ID-stage instruction info in, EX operand-mux selects and stall controls out
interface fwd_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W = 16
);
  logic id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic id_uses_rt;
  logic [REG_ADDR_W-1:0] id_dst;
  logic id_regwrite;
  logic id_memread;
  logic flush;
  logic fwd_a_sel1;
  logic fwd_a_sel2;
  logic fwd_b_sel1;
  logic fwd_b_sel2;
  logic stall;
  logic pc_write;
  logic ifid_write;
  logic ex_bubble;
  logic [CNT_W-1:0] stall_count;
  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt, id_dst, id_regwrite, id_memread, flush,
    input fwd_a_sel1, fwd_a_sel2, fwd_b_sel1, fwd_b_sel2, stall, pc_write, ifid_write,
    ex_bubble, stall_count
  );
  modport slave (
    input id_valid, id_rs, id_rt, id_uses_rt, id_dst, id_regwrite, id_memread, flush,
    output fwd_a_sel1, fwd_a_sel2, fwd_b_sel1, fwd_b_sel2, stall, pc_write, ifid_write,
    ex_bubble, stall_count
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX/MEM shadow pipeline driving operand forwarding selects and one-cycle load-use stalls
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset_n,
  fwd_hazard_ctrl_if.slave bus
);
  logic ex_v, ex_rw, ex_mr, mem_v, mem_rw;
  logic [REG_ADDR_W-1:0] ex_dst, mem_dst;
  logic [1:0] sel_a, sel_b, fwd_a, fwd_b;
  logic ex_bub, stall, kill;
  logic [CNT_W-1:0] cnt;
  assign stall = bus.id_valid & ~bus.flush & ex_v & ex_mr & (ex_dst != '0) &
                 ((ex_dst == bus.id_rs) | (bus.id_uses_rt & (ex_dst == bus.id_rt)));
  assign kill = bus.flush | stall | ~bus.id_valid;
  // EX match is checked first so the newest producer wins; WB hits fall through to the register file
  assign fwd_a = (bus.id_rs == '0) ? 2'b00 :
                 (ex_v & ex_rw & (ex_dst == bus.id_rs)) ? 2'b01 :
                 (mem_v & mem_rw & (mem_dst == bus.id_rs)) ? 2'b10 : 2'b00;
  assign fwd_b = (bus.id_rt == '0) ? 2'b00 :
                 (ex_v & ex_rw & (ex_dst == bus.id_rt)) ? 2'b01 :
                 (mem_v & mem_rw & (mem_dst == bus.id_rt)) ? 2'b10 : 2'b00;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_v <= 1'b0;
      ex_rw <= 1'b0;
      ex_mr <= 1'b0;
      ex_dst <= '0;
      mem_v <= 1'b0;
      mem_rw <= 1'b0;
      mem_dst <= '0;
      sel_a <= 2'b00;
      sel_b <= 2'b00;
      ex_bub <= 1'b1;
      cnt <= '0;
    end else begin
      mem_v <= ex_v;
      mem_rw <= ex_rw;
      mem_dst <= ex_dst;
      ex_v <= ~kill;
      ex_rw <= ~kill & bus.id_regwrite;
      ex_mr <= ~kill & bus.id_memread;
      ex_dst <= bus.id_dst;
      sel_a <= kill ? 2'b00 : fwd_a;
      sel_b <= kill ? 2'b00 : fwd_b;
      ex_bub <= kill;
      cnt <= cnt + CNT_W'(stall && (cnt != '1));
    end
  end
  assign {bus.fwd_a_sel1, bus.fwd_a_sel2} = sel_a;
  assign {bus.fwd_b_sel1, bus.fwd_b_sel2} = sel_b;
  assign bus.stall = stall;
  assign bus.pc_write = ~stall;
  assign bus.ifid_write = ~stall;
  assign bus.ex_bubble = ex_bub;
  assign bus.stall_count = cnt;
endmodule
